// File: rtl/sat_pkg.sv
// Shared DPLL types: trail entry layout, entry-type encodings and the backtrack FSM states.
package sat_pkg;

  localparam int unsigned DEFAULT_VARIABLE_INDEXES = 8;

  localparam logic TYPE_DECIDE = 1'b0;
  localparam logic TYPE_FORCED = 1'b1;

  // Sized at the default index width; parameterised users carry their own fields.
  typedef struct packed {
    logic                                etype;
    logic                                val;
    logic [DEFAULT_VARIABLE_INDEXES-1:0] vidx;
  } trail_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    EMIT,
    FLIP,
    DONE,
    UNSAT
  } bt_state_t;

endpackage

// File: rtl/backtrack_ctrl_if.sv
// Trace-stack port: push/pop controls from the controller, top-of-stack and status from the stack.
interface backtrack_ctrl_if #(
    parameter int unsigned VARIABLE_INDEXES = 8
);
    logic                        stk_push;
    logic                        stk_pop;
    logic                        stk_type_in;
    logic                        stk_val_in;
    logic [VARIABLE_INDEXES-1:0] stk_var_in;
    logic                        stk_type_out;
    logic                        stk_val_out;
    logic [VARIABLE_INDEXES-1:0] stk_var_out;
    logic                        stk_empty;
    logic                        stk_full;

    modport master (
        output stk_push, stk_pop, stk_type_in, stk_val_in, stk_var_in,
        input  stk_type_out, stk_val_out, stk_var_out, stk_empty, stk_full
    );

    modport slave (
        input  stk_push, stk_pop, stk_type_in, stk_val_in, stk_var_in,
        output stk_type_out, stk_val_out, stk_var_out, stk_empty, stk_full
    );
endinterface

// File: rtl/backtrack_ctrl_push_arb.sv
// Two-requester fixed-priority push mux: the high requester always wins, readys follow enable/full.
module push_arb #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              enable,
    input  logic              full,
    input  logic              hi_req,
    input  logic [DATA_W-1:0] hi_data,
    input  logic              lo_req,
    input  logic [DATA_W-1:0] lo_data,
    output logic              hi_ready,
    output logic              lo_ready,
    output logic              push,
    output logic              push_hi,
    output logic [DATA_W-1:0] push_data
);

    always_comb begin
        hi_ready  = enable & ~full;
        lo_ready  = enable & ~full & ~hi_req;
        push_hi   = hi_req & hi_ready;
        push      = push_hi | (lo_req & lo_ready);
        push_data = '0;
        if (push_hi)
            push_data = hi_data;
        else if (push)
            push_data = lo_data;
    end

endmodule

// File: rtl/backtrack_ctrl.sv
// DPLL trace-stack sequencer: arbitrates decision/implication pushes and runs chronological backtracking.
module backtrack_ctrl
    import sat_pkg::*;
#(
    parameter int unsigned VARIABLE_INDEXES = DEFAULT_VARIABLE_INDEXES,
    parameter int unsigned NUM_VARIABLE     = 128
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            imp_push,
    input  logic                            imp_val,
    input  logic [VARIABLE_INDEXES-1:0]     imp_var,
    output logic                            imp_ready,
    input  logic                            dec_push,
    input  logic                            dec_val,
    input  logic [VARIABLE_INDEXES-1:0]     dec_var,
    output logic                            dec_ready,
    input  logic                            conflict,
    output logic                            unassign_valid,
    output logic [VARIABLE_INDEXES-1:0]     unassign_var,
    input  logic                            unassign_ready,
    output logic                            assign_valid,
    output logic [VARIABLE_INDEXES-1:0]     assign_var,
    output logic                            assign_val,
    output logic                            bt_busy,
    output logic                            bt_done,
    output logic                            bt_unsat,
    output logic [$clog2(NUM_VARIABLE):0]   bt_popped,
    backtrack_ctrl_if.master                stk
);

    localparam int unsigned POP_W  = $clog2(NUM_VARIABLE) + 1;
    localparam int unsigned DATA_W = VARIABLE_INDEXES + 1;

    bt_state_t                   state;
    logic                        held_val;
    logic [VARIABLE_INDEXES-1:0] held_var;

    logic              arb_push;
    logic              arb_hi;
    logic [DATA_W-1:0] arb_data;

    push_arb #(
        .DATA_W(DATA_W)
    ) u_push_arb (
        .enable   ((state == IDLE) & ~conflict),
        .full     (stk.stk_full),
        .hi_req   (imp_push),
        .hi_data  ({imp_val, imp_var}),
        .lo_req   (dec_push),
        .lo_data  ({dec_val, dec_var}),
        .hi_ready (imp_ready),
        .lo_ready (dec_ready),
        .push     (arb_push),
        .push_hi  (arb_hi),
        .push_data(arb_data)
    );

    // FLIP re-pushes the held decision; in every other state the arbiter owns the push port.
    always_comb begin
        stk.stk_push    = arb_push;
        stk.stk_type_in = arb_hi ? TYPE_FORCED : TYPE_DECIDE;
        stk.stk_val_in  = arb_data[DATA_W-1];
        stk.stk_var_in  = arb_data[VARIABLE_INDEXES-1:0];
        if (state == FLIP) begin
            stk.stk_push    = 1'b1;
            stk.stk_type_in = TYPE_FORCED;
            stk.stk_val_in  = ~held_val;
            stk.stk_var_in  = held_var;
        end
        stk.stk_pop = (state == POP) & ~stk.stk_empty;
    end

    always_comb begin
        unassign_var = unassign_valid ? held_var : '0;
        assign_var   = assign_valid ? held_var : '0;
        assign_val   = assign_valid & ~held_val;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            held_val       <= 1'b0;
            held_var       <= '0;
            bt_popped      <= '0;
            unassign_valid <= 1'b0;
            assign_valid   <= 1'b0;
            bt_busy        <= 1'b0;
            bt_done        <= 1'b0;
            bt_unsat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (conflict) begin
                        state     <= POP;
                        bt_popped <= '0;
                        bt_busy   <= 1'b1;
                    end
                end
                POP: begin
                    if (stk.stk_empty) begin
                        state    <= UNSAT;
                        bt_busy  <= 1'b0;
                        bt_unsat <= 1'b1;
                    end else begin
                        held_val  <= stk.stk_val_out;
                        held_var  <= stk.stk_var_out;
                        bt_popped <= bt_popped + POP_W'(1);
                        if (stk.stk_type_out == TYPE_FORCED) begin
                            state          <= EMIT;
                            unassign_valid <= 1'b1;
                        end else begin
                            state        <= FLIP;
                            assign_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (unassign_ready) begin
                        state          <= POP;
                        unassign_valid <= 1'b0;
                    end
                end
                FLIP: begin
                    state        <= DONE;
                    assign_valid <= 1'b0;
                    bt_done      <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    bt_done <= 1'b0;
                    bt_busy <= 1'b0;
                end
                default: begin
                    state <= UNSAT;
                end
            endcase
        end
    end

endmodule
